config_port_arbiter: RTL and testbench

//  Shares the single configuration write port (WriteData/WriteStrobe/Reset) of the fabric config FSM

---
 rtl/config_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_config_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_port_arbiter.sv
// Shares the fabric config write port between the UART loader (src 0) and the bit-bang loader
// (src 1). Define CFG_ARB_TIMEOUT_EN to revoke sessions that sit idle for TimeoutCycles.
module config_port_arbiter #(
    parameter int unsigned NumberOfRows  = 15,
    parameter int unsigned desync_flag   = 20,
    parameter logic [31:0] SyncWord      = 32'hFAB0_FAB1,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned TimeoutWidth  = 11
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        UartActive,
    input  logic [31:0] UartData,
    input  logic        UartValid,
    output logic        UartReady,
    input  logic        BBActive,
    input  logic [31:0] BBData,
    input  logic        BBValid,
    output logic        BBReady,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ConfigReset,
    output logic [1:0]  Grant,
    output logic        AbortErr,
    input  logic        ErrClr
);

    localparam int unsigned RowCntW = $clog2(NumberOfRows + 1);

    if (2 ** TimeoutWidth <= TimeoutCycles) begin : g_timeout_width_check
        $error("TimeoutWidth is too narrow for TimeoutCycles");
    end

    typedef enum logic [1:0] {StIdle, StResync, StGrant} arb_state_e;
    typedef enum logic [1:0] {ShUnsync, ShSync, ShData} shadow_state_e;

    arb_state_e         state_q, state_d;
    shadow_state_e      shadow_q, shadow_d;
    logic               owner_q, owner_d;  // 0: UART, 1: bit-bang
    logic               last_src_q, last_src_d;
    logic               resync_cnt_q, resync_cnt_d;
    logic [RowCntW-1:0] row_cnt_q, row_cnt_d;
    logic               abort_err_q, abort_err_d;
    logic [31:0]        write_data_q, write_data_d;
    logic               write_strobe_q, write_strobe_d;

    logic [1:0]  req;
    logic [1:0]  req_eff;
    logic        owner_active;
    logic        owner_valid;
    logic [31:0] owner_data;
    logic        in_grant;
    logic        accept;
    logic        timeout_hit;
    logic        leave_grant;

    assign req          = {BBActive, UartActive};
    assign owner_active = owner_q ? BBActive : UartActive;
    assign owner_valid  = owner_q ? BBValid : UartValid;
    assign owner_data   = owner_q ? BBData : UartData;
    assign in_grant     = (state_q == StGrant);
    assign accept       = in_grant && owner_active && owner_valid;
    assign leave_grant  = in_grant && (!owner_active || timeout_hit);

`ifdef CFG_ARB_TIMEOUT_EN
    logic [TimeoutWidth-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [1:0]              blocked_q, blocked_d;

    assign req_eff     = req & ~blocked_q;
    assign timeout_hit = in_grant && owner_active && !accept &&
                         (timeout_cnt_q == TimeoutWidth'(TimeoutCycles - 1));

    always_comb begin
        timeout_cnt_d = '0;
        if (in_grant && !accept) begin
            timeout_cnt_d = timeout_cnt_q + TimeoutWidth'(1);
        end
        // A timed-out source stays locked out until its Active has been seen low
        blocked_d = blocked_q & req;
        if (timeout_hit) begin
            blocked_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            timeout_cnt_q <= '0;
            blocked_q     <= 2'b00;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
            blocked_q     <= blocked_d;
        end
    end
`else
    assign req_eff     = req;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_src_d   = last_src_q;
        resync_cnt_d = resync_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_eff != 2'b00) begin
                    // On a tie the source that did not win last time gets the port
                    owner_d      = (req_eff == 2'b11) ? ~last_src_q : req_eff[1];
                    last_src_d   = owner_d;
                    resync_cnt_d = 1'b0;
                    state_d      = StResync;
                end
            end
            StResync: begin
                resync_cnt_d = 1'b1;
                if (resync_cnt_q) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (leave_grant) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Shadow of the config FSM frame tracker, stepped only by forwarded words
    always_comb begin
        shadow_d  = shadow_q;
        row_cnt_d = row_cnt_q;
        if (state_q == StResync) begin
            shadow_d  = ShUnsync;
            row_cnt_d = '0;
        end else if (accept) begin
            unique case (shadow_q)
                ShUnsync: begin
                    if (owner_data == SyncWord) begin
                        shadow_d = ShSync;
                    end
                end
                ShSync: begin
                    if (owner_data[desync_flag]) begin
                        shadow_d = ShUnsync;
                    end else begin
                        shadow_d  = ShData;
                        row_cnt_d = RowCntW'(NumberOfRows);
                    end
                end
                ShData: begin
                    row_cnt_d = row_cnt_q - RowCntW'(1);
                    if (row_cnt_q == RowCntW'(1)) begin
                        shadow_d = ShSync;
                    end
                end
                default: shadow_d = ShUnsync;
            endcase
        end
    end

    always_comb begin
        abort_err_d = abort_err_q;
        if (ErrClr) begin
            abort_err_d = 1'b0;
        end
        if (leave_grant && (shadow_q == ShData)) begin
            abort_err_d = 1'b1;
        end
        write_strobe_d = accept;
        write_data_d   = accept ? owner_data : write_data_q;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            shadow_q       <= ShUnsync;
            owner_q        <= 1'b0;
            last_src_q     <= 1'b1;
            resync_cnt_q   <= 1'b0;
            row_cnt_q      <= '0;
            abort_err_q    <= 1'b0;
            write_data_q   <= '0;
            write_strobe_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            owner_q        <= owner_d;
            last_src_q     <= last_src_d;
            resync_cnt_q   <= resync_cnt_d;
            row_cnt_q      <= row_cnt_d;
            abort_err_q    <= abort_err_d;
            write_data_q   <= write_data_d;
            write_strobe_q <= write_strobe_d;
        end
    end

    assign WriteData   = write_data_q;
    assign WriteStrobe = write_strobe_q;
    assign ConfigReset = (state_q == StResync);
    assign Grant       = (state_q == StIdle) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign UartReady   = in_grant && !owner_q && UartActive;
    assign BBReady     = in_grant && owner_q && BBActive;
    assign AbortErr    = abort_err_q;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Scoreboard bench for config_port_arbiter: session-level reference model drives expectations,
// a negedge monitor pops expected write words and checks strobe latency.
`timescale 1ns/1ps
module tb_config_port_arbiter;

    localparam logic [31:0] SyncWord  = 32'hFAB0_FAB1;
    localparam int          Rows      = 15;
    localparam int          DesyncBit = 20;
`ifdef CFG_ARB_TIMEOUT_EN
    localparam int ToCycles = 8;
    localparam int ToWidth  = 4;
`else
    localparam int ToCycles = 1024;
    localparam int ToWidth  = 11;
`endif

    logic        CLK = 1'b0;
    logic        resetn;
    logic        UartActive, UartValid, UartReady;
    logic [31:0] UartData;
    logic        BBActive, BBValid, BBReady;
    logic [31:0] BBData;
    logic [31:0] WriteData;
    logic        WriteStrobe, ConfigReset, AbortErr, ErrClr;
    logic [1:0]  Grant;

    always #5 CLK = ~CLK;

    config_port_arbiter #(
        .NumberOfRows (Rows),
        .desync_flag  (DesyncBit),
        .SyncWord     (SyncWord),
        .TimeoutCycles(ToCycles),
        .TimeoutWidth (ToWidth)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .UartActive (UartActive),
        .UartData   (UartData),
        .UartValid  (UartValid),
        .UartReady  (UartReady),
        .BBActive   (BBActive),
        .BBData     (BBData),
        .BBValid    (BBValid),
        .BBReady    (BBReady),
        .WriteData  (WriteData),
        .WriteStrobe(WriteStrobe),
        .ConfigReset(ConfigReset),
        .Grant      (Grant),
        .AbortErr   (AbortErr),
        .ErrClr     (ErrClr)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] frame_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;

    // Reference model state: who won last, sticky error, frame position
    // (-1 unsynced, 0 expecting header, >0 data words still owed in the frame)
    int last_src = 1;
    bit abort_m = 1'b0;
    int fpos = -1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (WriteStrobe === 1'b1) strobe_cnt++;
        if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
            e = exp_q.pop_front();
            check("strobe", 32'(WriteStrobe), 32'd1);
            check("write_data", WriteData, e.data);
        end else if (WriteStrobe !== 1'b0) begin
            check("spurious_strobe", 32'(WriteStrobe), 32'd0);
        end
    end

    function automatic logic [1:0] onehot(input int src);
        return (src == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic int frame_next(input int p, input logic [31:0] w);
        if (p < 0) return (w == SyncWord) ? 0 : -1;
        if (p == 0) return w[DesyncBit] ? -1 : Rows;
        return p - 1;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SyncWord) w = w ^ 32'h1;
        return w;
    endfunction

    function automatic logic [31:0] hdr_word(input bit desync);
        logic [31:0] w;
        w = rnd_word();
        w[DesyncBit] = desync;
        if (w == SyncWord) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic drive(input int src, input bit act, input bit vld, input logic [31:0] data,
                         input bit other_act);
        if (src == 0) begin
            UartActive = act; UartValid = vld; UartData = data;
            BBActive = other_act; BBValid = 1'($urandom); BBData = $urandom;
        end else begin
            BBActive = act; BBValid = vld; BBData = data;
            UartActive = other_act; UartValid = 1'($urandom); UartData = $urandom;
        end
    endtask

    task automatic cycle_check(input string tag, input logic [1:0] g, input bit cr, input bit ur,
                               input bit br);
        @(negedge CLK);
        check({tag, "_grant"}, 32'(Grant), 32'(g));
        check({tag, "_cfgreset"}, 32'(ConfigReset), 32'(cr));
        check({tag, "_uart_ready"}, 32'(UartReady), 32'(ur));
        check({tag, "_bb_ready"}, 32'(BBReady), 32'(br));
        check({tag, "_abort"}, 32'(AbortErr), 32'(abort_m));
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_wdata"}, WriteData, 32'd0);
        check({tag, "_strobe"}, 32'(WriteStrobe), 32'd0);
        check({tag, "_cfgreset"}, 32'(ConfigReset), 32'd0);
        check({tag, "_grant"}, 32'(Grant), 32'd0);
        check({tag, "_abort"}, 32'(AbortErr), 32'd0);
        check({tag, "_ready"}, 32'({UartReady, BBReady}), 32'd0);
    endtask

    task automatic open_session(input bit [1:0] mask, output int win);
        UartActive = mask[0]; BBActive = mask[1];
        UartValid = 1'($urandom); BBValid = 1'($urandom);
        UartData = $urandom; BBData = $urandom;
        win = (mask == 2'b11) ? 1 - last_src : (mask[1] ? 1 : 0);
        last_src = win;
        fpos = -1;
        cycle_check("arb_idle", 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            UartValid = 1'($urandom); BBValid = 1'($urandom);
            cycle_check("resync", onehot(win), 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic send_word(input int src, input bit other, input logic [31:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            drive(src, 1'b1, 1'b0, $urandom, other);
            cycle_check("gap", onehot(src), 1'b0, src == 0, src == 1);
        end
        drive(src, 1'b1, 1'b1, w, other);
        exp_q.push_back('{data: w, cyc: cyc});
        fpos = frame_next(fpos, w);
        cycle_check("word", onehot(src), 1'b0, src == 0, src == 1);
    endtask

    task automatic send_frame(input int src, input bit other, input int gap_max);
        foreach (frame_q[i]) send_word(src, other, frame_q[i], $urandom_range(gap_max, 0));
    endtask

    task automatic close_session(input int src, input bit other, input bit clr);
        drive(src, 1'b0, 1'($urandom), $urandom, other);
        ErrClr = clr;
        cycle_check("drop", onehot(src), 1'b0, 1'b0, 1'b0);
        ErrClr = 1'b0;
        if (clr) abort_m = 1'b0;
        if (fpos > 0) abort_m = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1'b0, 1'b0, $urandom, 1'b0);
            cycle_check("idle", 2'b00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        drive(0, 1'b0, 1'b0, $urandom, 1'b0);
        ErrClr = 1'b1;
        cycle_check("errclr", 2'b00, 1'b0, 1'b0, 1'b0);
        ErrClr = 1'b0;
        abort_m = 1'b0;
        idle_cycles(1);
    endtask

    task automatic build_frame(input int kind);
        frame_q.delete();
        if (kind != 4) frame_q.push_back(SyncWord);
        case (kind)
            0: begin
                frame_q.push_back(hdr_word(1'b0));
                repeat (Rows) frame_q.push_back(rnd_word());
            end
            1: begin
                frame_q.push_back(hdr_word(1'b0));
                repeat ($urandom_range(Rows - 1, 1)) frame_q.push_back(rnd_word());
            end
            2: begin
                frame_q.push_back(hdr_word(1'b1));
                repeat ($urandom_range(3, 0)) frame_q.push_back(rnd_word());
            end
            3: begin
                frame_q.push_back(hdr_word(1'b0));
                repeat (Rows) frame_q.push_back(rnd_word());
                frame_q.push_back(hdr_word(1'b0));
                repeat ($urandom_range(Rows - 1, 1)) frame_q.push_back(rnd_word());
            end
            default: repeat ($urandom_range(4, 1)) frame_q.push_back(rnd_word());
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int win;
        int s0;
        bit [1:0] mask;
        resetn = 1'b0; ErrClr = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        reset_check("reset");
        repeat (2) @(posedge CLK);
        #1;
        resetn = 1'b1;
        idle_cycles(1);

        // Simultaneous requests after reset: UART wins, BB follows after one idle cycle
        open_session(2'b11, win);
        check("tie_winner", 32'(Grant), 32'(2'b01));
        send_word(win, 1'b1, SyncWord, 0);
        send_word(win, 1'b1, hdr_word(1'b1), 1);
        close_session(win, 1'b1, 1'b0);
        open_session(2'b10, win);
        send_word(win, 1'b0, rnd_word(), 0);
        close_session(win, 1'b0, 1'b0);
        idle_cycles(1);

        // Complete frame, back-to-back words
        s0 = strobe_cnt;
        open_session(2'b01, win);
        build_frame(0);
        send_frame(win, 1'b0, 0);
        close_session(win, 1'b0, 1'b0);
        idle_cycles(1);
        check("full_frame_strobes", 32'(strobe_cnt - s0), 32'd17);
        check("wdata_hold", WriteData, frame_q[frame_q.size() - 1]);

        // Session dropped mid-frame flags an abort, ErrClr clears it
        open_session(2'b10, win);
        frame_q.delete();
        frame_q.push_back(SyncWord);
        frame_q.push_back(hdr_word(1'b0));
        repeat (5) frame_q.push_back(rnd_word());
        send_frame(win, 1'b0, 2);
        close_session(win, 1'b0, 1'b0);
        idle_cycles(2);
        pulse_clr();

        // Desync header returns the shadow to UNSYNC, so a later header does not start a frame
        open_session(2'b01, win);
        frame_q.delete();
        frame_q.push_back(SyncWord);
        frame_q.push_back(hdr_word(1'b1));
        frame_q.push_back(hdr_word(1'b0));
        frame_q.push_back(rnd_word());
        send_frame(win, 1'b0, 1);
        close_session(win, 1'b0, 1'b0);
        idle_cycles(1);

        // Asynchronous reset in the middle of a frame
        open_session(2'b01, win);
        send_word(win, 1'b0, SyncWord, 0);
        send_word(win, 1'b0, hdr_word(1'b0), 0);
        repeat (3) send_word(win, 1'b0, rnd_word(), 0);
        drive(win, 1'b1, 1'b0, $urandom, 1'b0);
        cycle_check("pre_reset", onehot(win), 1'b0, 1'b1, 1'b0);
        drive(win, 1'b1, 1'b1, rnd_word(), 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        reset_check("async_reset");
        last_src = 1; abort_m = 1'b0; fpos = -1;
        repeat (2) begin
            @(negedge CLK);
            reset_check("held_reset");
            @(posedge CLK);
            #1;
        end
        resetn = 1'b1;
        open_session(2'b01, win);
        send_word(win, 1'b0, rnd_word(), 1);
        close_session(win, 1'b0, 1'b0);
        idle_cycles(1);

`ifdef CFG_ARB_TIMEOUT_EN
        // Idle session is revoked after ToCycles, owner locked out until Active drops
        open_session(2'b01, win);
        send_word(win, 1'b0, SyncWord, 0);
        send_word(win, 1'b0, hdr_word(1'b0), 0);
        send_word(win, 1'b0, rnd_word(), 0);
        repeat (ToCycles) begin
            drive(win, 1'b1, 1'b0, $urandom, 1'b0);
            cycle_check("to_wait", onehot(win), 1'b0, 1'b1, 1'b0);
        end
        if (fpos > 0) abort_m = 1'b1;
        repeat (3) begin
            drive(win, 1'b1, 1'b1, $urandom, 1'b0);
            cycle_check("to_blocked", 2'b00, 1'b0, 1'b0, 1'b0);
        end
        idle_cycles(1);
        open_session(2'b01, win);
        send_word(win, 1'b0, rnd_word(), 0);
        close_session(win, 1'b0, 1'b0);
        pulse_clr();
`endif

        // Randomised sessions against the reference model
        for (int n = 0; n < 30; n++) begin
            mask = 2'($urandom_range(3, 1));
            open_session(mask, win);
            build_frame($urandom_range(4, 0));
            send_frame(win, (win == 0) ? mask[1] : mask[0], $urandom_range(3, 0));
            close_session(win, 1'b0, ($urandom_range(3, 0) == 0));
            idle_cycles($urandom_range(2, 0));
            if ($urandom_range(4, 0) == 0) pulse_clr();
        end

        idle_cycles(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
